slave_rx_burst: RTL
===================

SLAVE_RX_BURST -- requirements
Module: slave_rx_burst

Interface
REQ-001 Parameter DATA_W, default 3, width of each received word.
REQ-002 Parameter MAX_BURST, default 4, maximum words accepted per request (>=1).
REQ-003 Parameter ACK_DELAY, default 100000000, clk cycles between request capture and ack assertion (>=1).
REQ-004 Parameter TIMEOUT, default 200000000, max clk cycles waiting for a valid word while ack is high (>=1).
REQ-005 Local LEN_W = clog2(MAX_BURST+1); CNT_W sized to hold max(ACK_DELAY, TIMEOUT).
REQ-006 clk  input  1  single clock; all state changes on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous and active-low.
REQ-008 request  input  1  master request, level, sampled in IDLE only.
REQ-009 burst_len  input  LEN_W  requested word count, sampled in the cycle request is accepted.
REQ-010 valid  input  1  master strobe; each high cycle in RECV carries one word.
REQ-011 data_in  input  DATA_W  word from master, sampled when valid=1 in RECV.
REQ-012 ack  output  1  registered; high exactly while in RECV.
REQ-013 notice  output  1  registered; high exactly while in WAIT_ACK.
REQ-014 data  output  DATA_W  registered; last accepted word, holds otherwise.
REQ-015 data_vld  output  1  registered one-cycle pulse per accepted word, aligned with data update.
REQ-016 word_idx  output  LEN_W  registered; index (0-based) of the word now on data.
REQ-017 done  output  1  one-cycle pulse when a burst completes normally.
REQ-018 err  output  1  one-cycle pulse when a RECV timeout aborts a burst.

Function
REQ-019 FSM states: IDLE, WAIT_ACK, RECV; no other reachable states; illegal encodings return to IDLE next cycle.
REQ-020 IDLE: request=1 -> WAIT_ACK next cycle; latch len = burst_len, with 0 mapped to 1 and values >MAX_BURST clamped to MAX_BURST; delay counter cleared.
REQ-021 WAIT_ACK: counter increments each cycle; when count reaches ACK_DELAY-1 -> RECV, so ack rises exactly ACK_DELAY cycles after the cycle notice rises.
REQ-022 WAIT_ACK ignores valid, data_in and request.
REQ-023 RECV: each cycle with valid=1 captures data_in into data, sets word_idx to words-accepted-so-far, pulses data_vld on the next cycle, and clears the timeout counter.
REQ-024 RECV: when the accepted word brings the count to len -> IDLE next cycle, ack low and done pulsed in that same next cycle.
REQ-025 RECV: valid=0 increments the timeout counter; on reaching TIMEOUT-1 with no valid -> IDLE, ack low, err pulsed; partially received words stay on data; no done.
REQ-026 Valid and timeout expiry in the same cycle: the word is accepted and the timeout is discarded.
REQ-027 request in WAIT_ACK or RECV is ignored; a request still high on return to IDLE starts a new transaction one cycle later (IDLE always lasts >=1 cycle).
REQ-028 Valid in IDLE or WAIT_ACK is discarded; data, word_idx unchanged, no data_vld.
REQ-029 data_vld, done, err are never high for more than one consecutive cycle; done and err are mutually exclusive.
REQ-030 Counters wrap-free: saturate/clear as stated, never wrap past their terminal value.

Reset
REQ-031 rst_n=0 asynchronously forces state=IDLE, ack=0, notice=0, data=0, data_vld=0, word_idx=0, done=0, err=0, all counters and len=0.
REQ-032 Reset asserted mid-burst aborts it without a done or err pulse; operation resumes from IDLE on the first rising edge after rst_n=1.

Verification (bench uses DATA_W=3, MAX_BURST=4, ACK_DELAY=4, TIMEOUT=8)
REQ-033 request=1, burst_len=3, after ack send 5,2,7 on consecutive valid cycles -> notice high 4 cycles, ack high, data 5/2/7 with word_idx 0/1/2 and data_vld pulses, done pulse, ack low after third word.
REQ-034 burst_len=0 then burst_len=7 -> first burst ends after 1 word, second after 4 words; done each time.
REQ-035 in RECV after 1 of 2 words, hold valid=0 -> err pulses after 8 idle cycles, ack drops, data keeps first word, no done.
REQ-036 valid pulses during IDLE and WAIT_ACK with data_in=6 -> data stays 0, no data_vld.
REQ-037 rst_n pulsed low asynchronously (between edges) during RECV -> all outputs 0 immediately, state IDLE, no done/err pulse.
REQ-038 request held high continuously across two bursts -> second notice rises exactly one cycle after IDLE re-entry.

Source files
------------

// File: rtl/slave_rx_burst_if.sv
// Handshake and data bus between a burst master and slave_rx_burst.
// The master drives the request and word strobes. The slave returns the handshake flags and the captured words.
interface slave_rx_burst_if #(
   parameter int DATA_W    = 3,
   parameter int MAX_BURST = 4
);
   localparam int LEN_W = $clog2(MAX_BURST + 1);

   logic              request;
   logic [LEN_W-1:0]  burst_len;
   logic              valid;
   logic [DATA_W-1:0] data_in;
   logic              ack;
   logic              notice;
   logic [DATA_W-1:0] data;
   logic              data_vld;
   logic [LEN_W-1:0]  word_idx;
   logic              done;
   logic              err;

   modport master (
      output request, burst_len, valid, data_in,
      input  ack, notice, data, data_vld, word_idx, done, err
   );

   modport slave (
      input  request, burst_len, valid, data_in,
      output ack, notice, data, data_vld, word_idx, done, err
   );
endinterface

// File: rtl/slave_rx_burst.sv
// Burst receiver. It accepts a request, waits ACK_DELAY cycles with notice high, and then acks.
// While acked it collects up to len words and ends with done, or with err if no word arrives within TIMEOUT cycles.
module slave_rx_burst #(
   parameter int DATA_W    = 3,
   parameter int MAX_BURST = 4,
   parameter int ACK_DELAY = 100000000,
   parameter int TIMEOUT   = 200000000
) (
   input logic            clk,
   input logic            rst_n,
   slave_rx_burst_if.slave bus
);
   localparam int LEN_W   = $clog2(MAX_BURST + 1);
   localparam int CNT_MAX = (ACK_DELAY > TIMEOUT) ? ACK_DELAY : TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_DELAY - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      RECV     = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;      // ack delay in WAIT_ACK, idle-cycle timeout in RECV
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] rcv_cnt;
   logic [LEN_W-1:0] len_next;

   // A zero request length still moves one word. Oversized requests are clamped.
   always_comb begin
      // NOTE: assign the default before any branch so that no path leaves len_next unassigned (which would infer a latch).
      len_next = bus.burst_len;
      if (bus.burst_len == '0)
         len_next = LEN_W'(1);
      else if (bus.burst_len > MAX_LEN)
         len_next = MAX_LEN;
   end

   // NOTE: all state updates use non-blocking assignments so every register samples the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         len          <= '0;
         rcv_cnt      <= '0;
         bus.ack      <= 1'b0;
         bus.notice   <= 1'b0;
         bus.data     <= '0;
         bus.data_vld <= 1'b0;
         bus.word_idx <= '0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.data_vld <= 1'b0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.request) begin
                  state      <= WAIT_ACK;
                  bus.notice <= 1'b1;
                  len        <= len_next;
                  cnt        <= '0;
                  rcv_cnt    <= '0;
               end
            end
            WAIT_ACK: begin
               if (cnt == ACK_LAST) begin
                  state      <= RECV;
                  bus.notice <= 1'b0;
                  bus.ack    <= 1'b1;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RECV: begin
               // A word arriving on the expiry cycle wins over the timeout.
               if (bus.valid) begin
                  bus.data     <= DATA_W'(bus.data_in);
                  bus.word_idx <= rcv_cnt;
                  bus.data_vld <= 1'b1;
                  rcv_cnt      <= rcv_cnt + LEN_W'(1);
                  cnt          <= '0;
                  if (rcv_cnt + LEN_W'(1) == len) begin
                     state    <= IDLE;
                     bus.ack  <= 1'b0;
                     bus.done <= 1'b1;
                  end
               end else if (cnt == TO_LAST) begin
                  state   <= IDLE;
                  bus.ack <= 1'b0;
                  bus.err <= 1'b1;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               bus.ack    <= 1'b0;
               bus.notice <= 1'b0;
               cnt        <= '0;
            end
         endcase
      end
   end
endmodule
